ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares one single-port, write-first RAM (ram_sp_wf) between NUM_REQ requesters, e.g. the CSR-to-RAM bridge and a hardware streaming engine.
- Arbitration is round-robin, one grant per cycle, with a bounded lock for back-to-back beats such as read-modify-write.
- Each requester's read data is routed back with a valid strobe that matches the RAM read latency.
- Sits between the requesters and the RAM instance, in place of a direct bridge-to-RAM connection.

Parameters:
- NUM_REQ, 2, number of requesters (>=2).
- WORD_BIT_WIDTH, 32, RAM word width (power of 2, >=8).
- WORD_ADDR_BIT_WIDTH, 3, RAM word-address width.
- USE_OUTPUT_REG, 1, must match the RAM setting; read latency RD_LAT = 1 + USE_OUTPUT_REG.
- MAX_LOCK_BEATS, 4, maximum consecutive grants to one locked requester (>=1).

Ports:
- i_clk  in  1  clock
- i_async_rst_n  in  1  asynchronous active-low reset
- i_req  in  NUM_REQ  per-requester access request
- i_lock  in  NUM_REQ  requester asks to keep the grant for its next beat
- i_we  in  NUM_REQ  1 = write, 0 = read
- i_word_addr  in  NUM_REQ x WORD_ADDR_BIT_WIDTH  word address
- i_wr_data  in  NUM_REQ x WORD_BIT_WIDTH  write data
- i_wr_byte_en  in  NUM_REQ x WORD_BIT_WIDTH/8  byte enables
- o_gnt  out  NUM_REQ  one-hot or zero; the access is performed at this clock edge
- o_rd_valid  out  NUM_REQ  one-hot or zero; read data returned to that requester
- o_rd_data  out  WORD_BIT_WIDTH  read data, broadcast to all requesters
- o_ram_we  out  1  RAM write enable
- o_ram_word_addr  out  WORD_ADDR_BIT_WIDTH  RAM address
- o_ram_wr_data  out  WORD_BIT_WIDTH  RAM write data
- o_ram_wr_byte_en  out  WORD_BIT_WIDTH/8  RAM byte enables
- i_ram_rd_data  in  WORD_BIT_WIDTH  RAM read data

Behaviour:
- Reset (async assert, sync deassert): round-robin pointer = 0; lock owner = none; lock count = 0; read-tag pipeline cleared.
  - Registered outputs o_rd_valid = 0 and o_rd_data = 0.
  - Combinational outputs are 0 whenever i_req = 0.
- Grant (combinational, same cycle as the request):
  - If a lock owner L exists, i_req[L]=1, i_lock[L]=1 and lock count < MAX_LOCK_BEATS, then o_gnt = L.
  - Otherwise o_gnt = the first set i_req bit searching from the pointer upward with wrap-around.
  - No request gives o_gnt = 0.
- RAM outputs are muxed from the granted requester. With no grant: o_ram_we=0, address/data/byte-en = 0.
- Pointer update at the edge: on a non-lock grant to k, pointer <= (k+1) mod NUM_REQ. A locked grant does not move the pointer.
- Lock tracking:
  - A grant to k with i_lock[k]=1 sets lock owner = k.
  - Lock count increments on each consecutive grant to the owner.
  - Reaching MAX_LOCK_BEATS forces normal rotation next cycle: owner cleared, pointer <= owner+1.
  - Owner deasserting i_req or i_lock clears the lock with no extra cycle.
  - MAX_LOCK_BEATS counts total consecutive grants, including the first.
- Writes complete at the grant edge. No response is generated.
- Read return: a read grant to k at edge T pushes tag k into an RD_LAT-deep shift register. At T+RD_LAT, o_rd_valid[k]=1 for one cycle and o_rd_data = i_ram_rd_data, registered.
  - Write grants push an empty tag.
  - Back-to-back reads from different requesters return in grant order, one per cycle.
- Requester rule: i_we, address, data, byte-en and lock must stay stable while i_req=1 and o_gnt=0.
- Reset mid-read: pending tags are discarded and no o_rd_valid follows.
- NUM_REQ=1 is not allowed; flag with an elaboration error.

Decomposition:
- ram_port_arbiter_pkg holds:
  - typedef ram_req_t {we, word_addr, wr_data, wr_byte_en}, parameterised via width localparams;
  - function rr_first_set(req, ptr), a round-robin search;
  - localparam computing RD_LAT.
- One sub-module: rr_prio_sel, a combinational round-robin selector (req vector, pointer -> one-hot grant, grant index).

Test Plan:
- Single requester 0 reads addr 3 (RAM preloaded 0xA5A5_0003), USE_OUTPUT_REG=1 -> o_gnt=01 at T, o_rd_valid=01 at T+2, o_rd_data=0xA5A5_0003.
- Both requesters hold i_req for 6 cycles, no lock -> grants alternate 01,10,01,10,01,10, each requester gets 3.
- Requester 1 locks with continuous i_req while requester 0 also requests, MAX_LOCK_BEATS=4 -> 4 consecutive grants to 1, then a grant to 0.
- Read-modify-write: requester 0 locks, reads addr 5 (=0x1111_1111), writes 0x2222_2222 with byte-en 0011 -> no foreign grant in between; a later read of addr 5 returns 0x1111_2222.
- Interleaved reads: R0 addr 1, R1 addr 2, R0 addr 3 on consecutive cycles -> o_rd_valid 01,10,01 on consecutive cycles with the matching data.
- Assert i_async_rst_n=0 one cycle after a read grant -> o_rd_valid stays 0 through T+3; after release, pointer = 0 and the first grant goes to requester 0 when both request.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg
// Shared types and helpers for the RAM port arbiter.
//   ram_req_t       : one requester's RAM command (we, word_addr, wr_data, wr_byte_en)
//   rr_first_set()  : round-robin search for the first set request bit
//   DEFAULT_RD_LAT  : RAM read latency for the default output-register setting
// The command widths live here so that every block exchanging ram_req_t
// agrees on them; the arbiter refuses to elaborate with different widths.
package ram_port_arbiter_pkg;

  localparam int PKG_WORD_BIT_WIDTH      = 32;
  localparam int PKG_WORD_ADDR_BIT_WIDTH = 3;
  localparam int PKG_BYTE_EN_BIT_WIDTH   = PKG_WORD_BIT_WIDTH / 8;

  localparam int DEFAULT_USE_OUTPUT_REG  = 1;
  localparam int DEFAULT_RD_LAT          = 1 + DEFAULT_USE_OUTPUT_REG;

  // Upper bound on requesters the round-robin helper can search.
  localparam int RR_MAX_REQ              = 16;
  localparam int RR_MAX_IDX_W            = $clog2(RR_MAX_REQ);

  typedef struct packed {
    logic                               we;
    logic [PKG_WORD_ADDR_BIT_WIDTH-1:0] word_addr;
    logic [PKG_WORD_BIT_WIDTH-1:0]      wr_data;
    logic [PKG_BYTE_EN_BIT_WIDTH-1:0]   wr_byte_en;
  } ram_req_t;

  // Returns the index of the first set bit of req[num_req-1:0], starting at
  // ptr and wrapping around, or -1 when no bit is set. Offsets are scanned
  // from the far end down so the smallest offset from ptr wins.
  function automatic int rr_first_set(input logic [RR_MAX_REQ-1:0] req,
                                      input int                    ptr,
                                      input int                    num_req);
    int idx;
    int found;
    found = -1;
    for (int off = RR_MAX_REQ - 1; off >= 0; off--) begin
      if (off < num_req) begin
        idx = ptr + off;
        if (idx >= num_req) idx = idx - num_req;
        if (req[idx[RR_MAX_IDX_W-1:0]]) found = idx;
      end
    end
    return found;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_prio_sel.sv
// rr_prio_sel
// Combinational round-robin selector.
//   req       : request vector
//   ptr       : index with the highest priority this cycle
//   gnt       : one-hot grant (zero when no request)
//   gnt_idx   : binary index of the granted requester (0 when none)
//   gnt_valid : a grant was made
module rr_prio_sel
  import ram_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
  output logic                       gnt_valid
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [RR_MAX_REQ-1:0] req_ext;
  int                    sel;

  always_comb begin
    req_ext              = '0;
    req_ext[NUM_REQ-1:0] = req;
    sel                  = rr_first_set(req_ext, int'(ptr), NUM_REQ);
    gnt                  = '0;
    gnt_idx              = '0;
    gnt_valid            = 1'b0;
    if (sel >= 0) begin
      gnt_valid    = 1'b1;
      gnt_idx      = IDX_W'(sel);
      gnt[gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares one single-port write-first RAM between NUM_REQ requesters with a
// round-robin grant, an optional bounded lock for back-to-back beats, and a
// read-return path whose valid strobe matches the RAM read latency.
//   i_clk, i_async_rst_n       : clock, asynchronous active-low reset
//   i_req/i_lock/i_we          : per-requester request, lock, write select
//   i_word_addr/i_wr_data/
//   i_wr_byte_en               : per-requester command fields
//   o_gnt                      : one-hot grant, access happens at this edge
//   o_rd_valid/o_rd_data       : registered read return (data broadcast)
//   o_ram_*                    : command to the RAM, zero when idle
//   i_ram_rd_data              : RAM read data
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ             = 2,
  parameter int WORD_BIT_WIDTH      = 32,
  parameter int WORD_ADDR_BIT_WIDTH = 3,
  parameter int USE_OUTPUT_REG      = 1,
  parameter int MAX_LOCK_BEATS      = 4
) (
  input  logic                                             i_clk,
  input  logic                                             i_async_rst_n,
  input  logic [NUM_REQ-1:0]                               i_req,
  input  logic [NUM_REQ-1:0]                               i_lock,
  input  logic [NUM_REQ-1:0]                               i_we,
  input  logic [NUM_REQ-1:0][WORD_ADDR_BIT_WIDTH-1:0]      i_word_addr,
  input  logic [NUM_REQ-1:0][WORD_BIT_WIDTH-1:0]           i_wr_data,
  input  logic [NUM_REQ-1:0][WORD_BIT_WIDTH/8-1:0]         i_wr_byte_en,
  output logic [NUM_REQ-1:0]                               o_gnt,
  output logic [NUM_REQ-1:0]                               o_rd_valid,
  output logic [WORD_BIT_WIDTH-1:0]                        o_rd_data,
  output logic                                             o_ram_we,
  output logic [WORD_ADDR_BIT_WIDTH-1:0]                   o_ram_word_addr,
  output logic [WORD_BIT_WIDTH-1:0]                        o_ram_wr_data,
  output logic [WORD_BIT_WIDTH/8-1:0]                      o_ram_wr_byte_en,
  input  logic [WORD_BIT_WIDTH-1:0]                        i_ram_rd_data
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int CNT_W  = $clog2(MAX_LOCK_BEATS + 1);
  localparam int RD_LAT = 1 + USE_OUTPUT_REG;

  if (NUM_REQ < 2) begin : g_err_num_req
    $error("ram_port_arbiter: NUM_REQ must be at least 2");
  end
  if (NUM_REQ > RR_MAX_REQ) begin : g_err_num_req_max
    $error("ram_port_arbiter: NUM_REQ exceeds RR_MAX_REQ");
  end
  if (MAX_LOCK_BEATS < 1) begin : g_err_lock
    $error("ram_port_arbiter: MAX_LOCK_BEATS must be at least 1");
  end
  if (USE_OUTPUT_REG != 0 && USE_OUTPUT_REG != 1) begin : g_err_outreg
    $error("ram_port_arbiter: USE_OUTPUT_REG must be 0 or 1");
  end
  if (WORD_BIT_WIDTH != PKG_WORD_BIT_WIDTH ||
      WORD_ADDR_BIT_WIDTH != PKG_WORD_ADDR_BIT_WIDTH) begin : g_err_width
    $error("ram_port_arbiter: widths must match ram_port_arbiter_pkg");
  end

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } rd_tag_t;

  logic [IDX_W-1:0] ptr_q;
  logic             lock_valid_q;
  logic [IDX_W-1:0] lock_owner_q;
  logic [CNT_W-1:0] lock_cnt_q;

  logic [NUM_REQ-1:0] rr_gnt;
  logic [IDX_W-1:0]   rr_idx;
  logic               rr_valid;

  logic               lock_hold;
  logic               gnt_valid;
  logic [IDX_W-1:0]   gnt_idx;
  ram_req_t           sel_req;

  rd_tag_t            tag_pipe_q [RD_LAT];
  rd_tag_t            new_tag;
  rd_tag_t            last_tag;

  function automatic logic [IDX_W-1:0] idx_next(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

  rr_prio_sel #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_prio_sel (
    .req       (i_req),
    .ptr       (ptr_q),
    .gnt       (rr_gnt),
    .gnt_idx   (rr_idx),
    .gnt_valid (rr_valid)
  );

  // The lock owner keeps the port only while it still requests and locks
  // and has beats left; otherwise plain round-robin decides.
  assign lock_hold = lock_valid_q && i_req[lock_owner_q] && i_lock[lock_owner_q] &&
                     (lock_cnt_q < CNT_W'(MAX_LOCK_BEATS));

  always_comb begin
    gnt_valid = lock_hold | rr_valid;
    gnt_idx   = lock_hold ? lock_owner_q : rr_idx;
    o_gnt     = rr_gnt;
    if (lock_hold) begin
      o_gnt               = '0;
      o_gnt[lock_owner_q] = 1'b1;
    end
  end

  always_comb begin
    sel_req = '0;
    if (gnt_valid) begin
      sel_req.we         = i_we[gnt_idx];
      sel_req.word_addr  = i_word_addr[gnt_idx];
      sel_req.wr_data    = i_wr_data[gnt_idx];
      sel_req.wr_byte_en = i_wr_byte_en[gnt_idx];
    end
  end

  assign o_ram_we         = sel_req.we;
  assign o_ram_word_addr  = sel_req.word_addr;
  assign o_ram_wr_data    = sel_req.wr_data;
  assign o_ram_wr_byte_en = sel_req.wr_byte_en;

  // The lock count includes the opening grant, so the beat that brings it to
  // MAX_LOCK_BEATS releases the lock and hands priority to the next index.
  always_ff @(posedge i_clk or negedge i_async_rst_n) begin
    if (!i_async_rst_n) begin
      ptr_q        <= '0;
      lock_valid_q <= 1'b0;
      lock_owner_q <= '0;
      lock_cnt_q   <= '0;
    end else if (lock_hold) begin
      if (lock_cnt_q == CNT_W'(MAX_LOCK_BEATS - 1)) begin
        lock_valid_q <= 1'b0;
        lock_cnt_q   <= '0;
        ptr_q        <= idx_next(lock_owner_q);
      end else begin
        lock_cnt_q <= lock_cnt_q + CNT_W'(1);
      end
    end else if (rr_valid) begin
      ptr_q <= idx_next(rr_idx);
      if (i_lock[rr_idx] && (MAX_LOCK_BEATS > 1)) begin
        lock_valid_q <= 1'b1;
        lock_owner_q <= rr_idx;
        lock_cnt_q   <= CNT_W'(1);
      end else begin
        lock_valid_q <= 1'b0;
        lock_cnt_q   <= '0;
      end
    end else begin
      lock_valid_q <= 1'b0;
      lock_cnt_q   <= '0;
    end
  end

  // Every grant pushes a tag so returns stay aligned with the RAM pipeline;
  // writes push an empty one.
  always_comb begin
    new_tag       = '0;
    new_tag.valid = gnt_valid & ~sel_req.we;
    new_tag.idx   = gnt_idx;
  end

  assign last_tag = tag_pipe_q[RD_LAT-1];

  always_ff @(posedge i_clk or negedge i_async_rst_n) begin
    if (!i_async_rst_n) begin
      for (int i = 0; i < RD_LAT; i++) tag_pipe_q[i] <= '0;
    end else begin
      tag_pipe_q[0] <= new_tag;
      for (int i = 1; i < RD_LAT; i++) tag_pipe_q[i] <= tag_pipe_q[i-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_async_rst_n) begin
    if (!i_async_rst_n) begin
      o_rd_valid <= '0;
      o_rd_data  <= '0;
    end else begin
      o_rd_valid <= '0;
      if (last_tag.valid) begin
        o_rd_valid[last_tag.idx] <= 1'b1;
        o_rd_data                <= i_ram_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
// Directed bench for ram_port_arbiter with a behavioural write-first RAM
// (output register on, read latency 2). Grants and RAM commands are checked
// in the cycle they are issued; read returns go through a scoreboard queue
// holding the requester, the data and the cycle the return is due.
module tb_ram_port_arbiter;

  localparam int RD_LAT = 2;

  logic              i_clk;
  logic              i_async_rst_n;
  logic [1:0]        req;
  logic [1:0]        lock;
  logic [1:0]        we;
  logic [1:0][2:0]   addr;
  logic [1:0][31:0]  wdata;
  logic [1:0][3:0]   be;
  logic [1:0]        o_gnt;
  logic [1:0]        o_rd_valid;
  logic [31:0]       o_rd_data;
  logic              o_ram_we;
  logic [2:0]        o_ram_word_addr;
  logic [31:0]       o_ram_wr_data;
  logic [3:0]        o_ram_wr_byte_en;
  logic [31:0]       ram_rd_data;

  typedef struct {
    int          idx;
    logic [31:0] data;
    int          due;
  } rd_exp_t;

  rd_exp_t sb[$];
  int      total = 0;
  int      bad   = 0;
  int      cyc   = 0;
  int      n_gnt0;
  int      n_gnt1;

  logic [31:0] mem [8];
  logic [31:0] ram_merged;
  logic [31:0] ram_stage;

  ram_port_arbiter #(
    .NUM_REQ             (2),
    .WORD_BIT_WIDTH      (32),
    .WORD_ADDR_BIT_WIDTH (3),
    .USE_OUTPUT_REG      (1),
    .MAX_LOCK_BEATS      (4)
  ) dut (
    .i_clk            (i_clk),
    .i_async_rst_n    (i_async_rst_n),
    .i_req            (req),
    .i_lock           (lock),
    .i_we             (we),
    .i_word_addr      (addr),
    .i_wr_data        (wdata),
    .i_wr_byte_en     (be),
    .o_gnt            (o_gnt),
    .o_rd_valid       (o_rd_valid),
    .o_rd_data        (o_rd_data),
    .o_ram_we         (o_ram_we),
    .o_ram_word_addr  (o_ram_word_addr),
    .o_ram_wr_data    (o_ram_wr_data),
    .o_ram_wr_byte_en (o_ram_wr_byte_en),
    .i_ram_rd_data    (ram_rd_data)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  always @(posedge i_clk) cyc <= cyc + 1;

  // Write-first single-port RAM with an output register.
  always_comb begin
    ram_merged = mem[o_ram_word_addr];
    for (int b = 0; b < 4; b++)
      if (o_ram_wr_byte_en[b]) ram_merged[8*b +: 8] = o_ram_wr_data[8*b +: 8];
  end

  always @(posedge i_clk) begin
    if (o_ram_we) mem[o_ram_word_addr] <= ram_merged;
    ram_stage   <= o_ram_we ? ram_merged : mem[o_ram_word_addr];
    ram_rd_data <= ram_stage;
  end

  // Read-return monitor: a due entry must appear exactly then; any other
  // valid strobe is unexpected.
  always @(negedge i_clk) begin
    if (i_async_rst_n) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        total++;
        assert (o_rd_valid === ((sb[0].idx == 1) ? 2'b10 : 2'b01) && o_rd_data === sb[0].data)
        else begin
          bad++;
          $error("[TB] FAIL rd_return valid=%b data=%h want_req=%0d want_data=%h",
                 o_rd_valid, o_rd_data, sb[0].idx, sb[0].data);
        end
        void'(sb.pop_front());
      end else if (o_rd_valid !== 2'b00) begin
        total++;
        assert (o_rd_valid === 2'b00)
        else begin
          bad++;
          $error("[TB] FAIL rd_spurious valid=%b want=00", o_rd_valid);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] l, input logic [1:0] w,
                               input logic [2:0] a0, input logic [2:0] a1,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input logic [3:0] b0, input logic [3:0] b1);
    @(negedge i_clk);
    req      = r;
    lock     = l;
    we       = w;
    addr[0]  = a0;
    addr[1]  = a1;
    wdata[0] = d0;
    wdata[1] = d1;
    be[0]    = b0;
    be[1]    = b1;
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] exp_gnt,
                             input logic [31:0] exp_rd);
    logic k;
    #1;
    total++;
    assert (o_gnt === exp_gnt)
    else begin
      bad++;
      $error("[TB] FAIL %s gnt got=%b want=%b", tag, o_gnt, exp_gnt);
    end
    if (exp_gnt != 2'b00) begin
      k = exp_gnt[1];
      total++;
      assert (o_ram_we === we[k] && o_ram_word_addr === addr[k])
      else begin
        bad++;
        $error("[TB] FAIL %s ram_cmd we=%b addr=%0d want we=%b addr=%0d",
               tag, o_ram_we, o_ram_word_addr, we[k], addr[k]);
      end
      if (we[k]) begin
        total++;
        assert (o_ram_wr_data === wdata[k] && o_ram_wr_byte_en === be[k])
        else begin
          bad++;
          $error("[TB] FAIL %s ram_wr data=%h be=%b want data=%h be=%b",
                 tag, o_ram_wr_data, o_ram_wr_byte_en, wdata[k], be[k]);
        end
      end else begin
        sb.push_back('{idx: int'(k), data: exp_rd, due: cyc + 1 + RD_LAT});
      end
    end else begin
      total++;
      assert (o_ram_we === 1'b0 && o_ram_word_addr === 3'd0 &&
              o_ram_wr_data === 32'd0 && o_ram_wr_byte_en === 4'd0)
      else begin
        bad++;
        $error("[TB] FAIL %s ram_idle we=%b addr=%0d data=%h be=%b want all zero",
               tag, o_ram_we, o_ram_word_addr, o_ram_wr_data, o_ram_wr_byte_en);
      end
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 32'd0, 32'd0, 4'd0, 4'd0);
      checkOutput("idle", 2'b00, 32'd0);
    end
  endtask

  task automatic checkRdValidZero(input string tag);
    total++;
    assert (o_rd_valid === 2'b00)
    else begin
      bad++;
      $error("[TB] FAIL %s rd_valid got=%b want=00", tag, o_rd_valid);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] <= 32'hA5A5_0000 + 32'(i);
    mem[5] <= 32'h1111_1111;
    i_async_rst_n = 1'b0;
    req = '0; lock = '0; we = '0; addr = '0; wdata = '0; be = '0;

    // Reset values
    repeat (2) @(negedge i_clk);
    #1;
    checkRdValidZero("reset");
    total++;
    assert (o_rd_data === 32'd0)
    else begin
      bad++;
      $error("[TB] FAIL reset rd_data got=%h want=0", o_rd_data);
    end
    checkOutput("reset_idle", 2'b00, 32'd0);
    i_async_rst_n = 1'b1;
    $display("[TB] reset released");

    // Single read, requester 0, addr 3
    applyStimulus(2'b01, 2'b00, 2'b00, 3'd3, 3'd0, 32'd0, 32'd0, 4'd0, 4'd0);
    checkOutput("single_rd", 2'b01, 32'hA5A5_0003);
    idleCycles(3);

    // Both requesting, no lock: strict alternation (pointer now at 1)
    n_gnt0 = 0;
    n_gnt1 = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(2'b11, 2'b00, 2'b00, 3'd1, 3'd2, 32'd0, 32'd0, 4'd0, 4'd0);
      checkOutput("alternate", (i % 2 == 0) ? 2'b10 : 2'b01,
                  (i % 2 == 0) ? 32'hA5A5_0002 : 32'hA5A5_0001);
      if (o_gnt === 2'b01) n_gnt0++;
      if (o_gnt === 2'b10) n_gnt1++;
    end
    total++;
    assert (n_gnt0 === 3 && n_gnt1 === 3)
    else begin
      bad++;
      $error("[TB] FAIL fairness got=%0d/%0d want=3/3", n_gnt0, n_gnt1);
    end
    idleCycles(3);

    // Requester 1 locks continuously: 4 beats, then requester 0
    for (int i = 0; i < 5; i++) begin
      applyStimulus(2'b11, 2'b10, 2'b00, 3'd1, 3'd2, 32'd0, 32'd0, 4'd0, 4'd0);
      checkOutput("lock_max", (i < 4) ? 2'b10 : 2'b01,
                  (i < 4) ? 32'hA5A5_0002 : 32'hA5A5_0001);
    end
    idleCycles(3);

    // Read-modify-write by requester 0 under lock while requester 1 competes
    applyStimulus(2'b11, 2'b01, 2'b00, 3'd5, 3'd2, 32'd0, 32'd0, 4'd0, 4'd0);
    checkOutput("rmw_wait", 2'b10, 32'hA5A5_0002);
    applyStimulus(2'b11, 2'b01, 2'b00, 3'd5, 3'd2, 32'd0, 32'd0, 4'd0, 4'd0);
    checkOutput("rmw_rd", 2'b01, 32'h1111_1111);
    applyStimulus(2'b11, 2'b01, 2'b01, 3'd5, 3'd2, 32'h2222_2222, 32'd0, 4'b0011, 4'd0);
    checkOutput("rmw_wr", 2'b01, 32'd0);
    applyStimulus(2'b10, 2'b00, 2'b00, 3'd0, 3'd2, 32'd0, 32'd0, 4'd0, 4'd0);
    checkOutput("rmw_release", 2'b10, 32'hA5A5_0002);
    idleCycles(3);
    applyStimulus(2'b01, 2'b00, 2'b00, 3'd5, 3'd0, 32'd0, 32'd0, 4'd0, 4'd0);
    checkOutput("rmw_verify", 2'b01, 32'h1111_2222);
    idleCycles(3);

    // Interleaved single reads on consecutive cycles
    applyStimulus(2'b01, 2'b00, 2'b00, 3'd1, 3'd0, 32'd0, 32'd0, 4'd0, 4'd0);
    checkOutput("ilv_r0a", 2'b01, 32'hA5A5_0001);
    applyStimulus(2'b10, 2'b00, 2'b00, 3'd0, 3'd2, 32'd0, 32'd0, 4'd0, 4'd0);
    checkOutput("ilv_r1", 2'b10, 32'hA5A5_0002);
    applyStimulus(2'b01, 2'b00, 2'b00, 3'd3, 3'd0, 32'd0, 32'd0, 4'd0, 4'd0);
    checkOutput("ilv_r0b", 2'b01, 32'hA5A5_0003);
    idleCycles(3);

    // Reset one cycle after a read grant discards the pending return
    applyStimulus(2'b01, 2'b00, 2'b00, 3'd3, 3'd0, 32'd0, 32'd0, 4'd0, 4'd0);
    checkOutput("rst_rd", 2'b01, 32'hA5A5_0003);
    @(negedge i_clk);
    req = 2'b00;
    sb.delete();
    i_async_rst_n = 1'b0;
    #1;
    checkRdValidZero("rst_mid_t1");
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      #1;
      checkRdValidZero("rst_mid_hold");
    end
    i_async_rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge i_clk);
      #1;
      checkRdValidZero("rst_after");
    end
    applyStimulus(2'b11, 2'b00, 2'b00, 3'd1, 3'd2, 32'd0, 32'd0, 4'd0, 4'd0);
    checkOutput("rst_ptr0", 2'b01, 32'hA5A5_0001);
    idleCycles(4);

    total++;
    assert (sb.size() === 0)
    else begin
      bad++;
      $error("[TB] FAIL sb_drain pending=%0d want=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
